// File: rtl/midi_voice_scheduler_pkg.sv
// Shared MIDI constants and the parser-to-allocator event payload.
package midi_voice_scheduler_pkg;

  // Status nibbles of the channel messages the parser distinguishes
  localparam logic [3:0] STS_NOTE_OFF = 4'h8;
  localparam logic [3:0] STS_NOTE_ON  = 4'h9;
  localparam logic [3:0] STS_CC       = 4'hB;
  localparam logic [3:0] STS_PROG     = 4'hC;
  localparam logic [3:0] STS_CHPRESS  = 4'hD;

  // Bytes at or above RT_MIN are real-time; SYS_MIN..RT_MIN-1 are system common/exclusive
  localparam logic [7:0] RT_MIN  = 8'hF8;
  localparam logic [7:0] SYS_MIN = 8'hF0;

  // Controller numbers that release every voice
  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_ON      = 2'd1,
    EVT_OFF     = 2'd2,
    EVT_ALL_OFF = 2'd3
  } evt_e;

  typedef struct packed {
    evt_e       evt;
    logic [6:0] note;
    logic [6:0] vel;
  } midi_evt_t;

endpackage

// File: rtl/midi_voice_scheduler_msg_parser.sv
// MIDI byte-stream parser: running status, real-time passthrough, one registered event per message.
module midi_voice_scheduler_msg_parser
  import midi_voice_scheduler_pkg::*;
#(
  parameter int unsigned MIDI_CHANNEL = 0,
  parameter int unsigned OMNI         = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output midi_evt_t  evt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_D1   = 2'd1,
    ST_D2   = 2'd2
  } pstate_e;

  pstate_e    state;
  logic [7:0] status;
  logic [6:0] d1;
  logic       ch_ok_c;
  logic       one_byte_c;
  midi_evt_t  dec_c;

  assign ch_ok_c    = (OMNI != 0) || (status[3:0] == 4'(MIDI_CHANNEL));
  assign one_byte_c = (status[7:4] == STS_PROG) || (status[7:4] == STS_CHPRESS);

  // Decode the completed two-byte message held in status/d1 plus the current data byte
  always_comb begin
    dec_c.evt  = EVT_NONE;
    dec_c.note = d1;
    dec_c.vel  = rx_data[6:0];
    if (ch_ok_c) begin
      case (status[7:4])
        STS_NOTE_ON:  dec_c.evt = (rx_data[6:0] != 7'd0) ? EVT_ON : EVT_OFF;
        STS_NOTE_OFF: dec_c.evt = EVT_OFF;
        STS_CC: begin
          if ((d1 == CC_ALL_NOTES_OFF) || (d1 == CC_ALL_SOUND_OFF)) dec_c.evt = EVT_ALL_OFF;
        end
        default: dec_c.evt = EVT_NONE;
      endcase
    end
  end

  // Parser state machine; the event register defaults to NONE so events last one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      status   <= 8'h00;
      d1       <= 7'd0;
      evt.evt  <= EVT_NONE;
      evt.note <= 7'd0;
      evt.vel  <= 7'd0;
    end else begin
      evt.evt <= EVT_NONE;
      if (rx_valid) begin
        if (rx_data >= RT_MIN) begin
          state <= state;
        end else if (rx_data >= SYS_MIN) begin
          state  <= ST_IDLE;
          status <= 8'h00;
        end else if (rx_data[7]) begin
          status <= rx_data;
          state  <= ST_D1;
        end else begin
          case (state)
            ST_D1: begin
              d1    <= rx_data[6:0];
              state <= one_byte_c ? ST_D1 : ST_D2;
            end
            ST_D2: begin
              evt   <= dec_c;
              state <= ST_D1;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/midi_voice_scheduler.sv
// Voice allocator: maps parsed note events onto NUM_VOICES slots (retrigger, free-first, oldest-steal).
module midi_voice_scheduler
  import midi_voice_scheduler_pkg::*;
#(
  parameter int unsigned NUM_VOICES   = 4,
  parameter int unsigned MIDI_CHANNEL = 0,
  parameter int unsigned OMNI         = 0,
  parameter int unsigned AGE_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    panic,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic                    steal
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  midi_evt_t        evt;
  logic [6:0]       note_q [NUM_VOICES];
  logic [6:0]       vel_q  [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];

  logic             hit_c;
  logic             free_c;
  logic [IDX_W-1:0] hit_idx_c;
  logic [IDX_W-1:0] free_idx_c;
  logic [IDX_W-1:0] old_idx_c;
  logic [AGE_W-1:0] old_age_c;
  logic [IDX_W-1:0] tgt_idx_c;

  midi_voice_scheduler_msg_parser #(
    .MIDI_CHANNEL (MIDI_CHANNEL),
    .OMNI         (OMNI)
  ) u_parser (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .evt      (evt)
  );

  // Find same-note active voice, lowest free voice and oldest voice (ties to lowest index)
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    old_idx_c  = '0;
    old_age_c  = age_q[0];
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (voice_gate[i] && (note_q[i] == evt.note) && !hit_c) begin
        hit_c     = 1'b1;
        hit_idx_c = IDX_W'(i);
      end
      if (!voice_gate[i] && !free_c) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
      if (age_q[i] > old_age_c) begin
        old_age_c = age_q[i];
        old_idx_c = IDX_W'(i);
      end
    end
    tgt_idx_c = hit_c ? hit_idx_c : (free_c ? free_idx_c : old_idx_c);
  end

  // Voice register array; panic and all-off take precedence over any pending event
  always_ff @(posedge clk) begin
    if (rst) begin
      voice_gate <= '0;
      voice_trig <= '0;
      steal      <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= 7'd0;
        vel_q[i]  <= 7'd0;
        age_q[i]  <= '0;
      end
    end else begin
      voice_trig <= '0;
      steal      <= 1'b0;
      if (panic || (evt.evt == EVT_ALL_OFF)) begin
        voice_gate <= '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
      end else if (evt.evt == EVT_ON) begin
        steal <= !hit_c && !free_c;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (IDX_W'(i) == tgt_idx_c) begin
            note_q[i]     <= evt.note;
            vel_q[i]      <= evt.vel;
            age_q[i]      <= '0;
            voice_gate[i] <= 1'b1;
            voice_trig[i] <= 1'b1;
          end else if (voice_gate[i] && (age_q[i] != AGE_MAX)) begin
            age_q[i] <= age_q[i] + AGE_W'(1);
          end
        end
      end else if (evt.evt == EVT_OFF) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (voice_gate[i] && (note_q[i] == evt.note)) voice_gate[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten per-voice note/velocity registers onto the output buses
  for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_flat
    assign voice_note[7*g +: 7] = note_q[g];
    assign voice_vel[7*g +: 7]  = vel_q[g];
  end

endmodule
